// File: rtl/sysarr_drain_if.sv
// Downstream row stream of the systolic-array drain: aligned row, valid, ready.
// master = producer of rows (sysarr_drain), slave = consumer.
interface sysarr_drain_if #(
  parameter int WORD_LEN = 4,
  parameter int ARR_WDT  = 4
);
  logic [ARR_WDT*2*WORD_LEN-1:0] out_data;
  logic                          out_vld;
  logic                          out_rdy;

  modport master (output out_data, output out_vld, input out_rdy);
  modport slave  (input out_data, input out_vld, output out_rdy);
endinterface

// File: rtl/sysarr_drain.sv
// Systolic-array result drain: deskews the lanes, buffers aligned rows in a show-ahead
// FIFO and counts rows per job. Define SYSARR_DRAIN_RELU_EN to ReLU each output lane.
module sysarr_drain #(
  parameter int WORD_LEN   = 4,
  parameter int ARR_WDT    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   num_rows,
  input  logic [ARR_WDT*2*WORD_LEN-1:0] ps_in,
  input  logic                          in_vld,
  sysarr_drain_if.master                m_out,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int LW = 2 * WORD_LEN;
  localparam int RW = ARR_WDT * LW;
  localparam int D  = ARR_WDT - 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_start_ok;
  logic [15:0]     r_num_rows, r_issued, r_row_cnt;
  logic            r_ovf;
  logic            w_acc, w_avld, w_row_last;
  logic [D-1:0]    r_vld_p;
  logic [RW-1:0]   w_row;
  logic [RW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [AW:0]     r_cnt, w_remain;
  logic            w_full, w_push, w_pop, w_drop;
  logic [RW-1:0]   r_out_data, w_head_nxt;

`ifdef SYSARR_DRAIN_RELU_EN
  function automatic logic [LW-1:0] relu_lane(input logic signed [LW-1:0] x);
    return (x < 0) ? '0 : x;
  endfunction

  function automatic logic [RW-1:0] relu_row(input logic [RW-1:0] row);
    logic [RW-1:0] res;
    for (int j = 0; j < ARR_WDT; j++) res[j*LW +: LW] = relu_lane(row[j*LW +: LW]);
    return res;
  endfunction
`endif

  assign w_acc = in_vld && (r_state == S_COLLECT) && (r_issued < r_num_rows);

  // Stage p0 -> p(D): lane j rides D-j registers so every lane lands in the same cycle
  for (genvar j = 0; j < ARR_WDT; j++) begin : g_lane
    if (j == ARR_WDT - 1) begin : g_direct
      assign w_row[j*LW +: LW] = ps_in[j*LW +: LW];
    end else begin : g_dly
      logic [LW-1:0] r_sr_p [D-j];
      always_ff @(posedge clk) begin
        r_sr_p[0] <= ps_in[j*LW +: LW];
        for (int k = 1; k < D - j; k++) r_sr_p[k] <= r_sr_p[k-1];
      end
      assign w_row[j*LW +: LW] = r_sr_p[D-j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_acc;
      for (int k = 1; k < D; k++) r_vld_p[k] <= r_vld_p[k-1];
    end
  end

  assign w_avld = r_vld_p[D-1];

  // Aligned row -> FIFO; a full FIFO with no pop drops the row since the array cannot stall
  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) && m_out.out_rdy;
  assign w_push = w_avld && (!w_full || w_pop);
  assign w_drop = w_avld && w_full && !w_pop;

  assign w_rd_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_remain = r_cnt - (AW+1)'(w_pop);

  always_comb begin
    w_head_nxt = r_out_data;
    if (w_remain != '0)  w_head_nxt = r_mem[w_rd_nxt];
    else if (w_push)     w_head_nxt = w_row;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_row;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr   <= w_rd_nxt;
      r_cnt      <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_out_data <= w_head_nxt;
    end
  end

  // Job control
  assign w_row_last = ((r_row_cnt + 16'd1) == r_num_rows);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = (num_rows == 16'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: if (w_avld && w_row_last) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_rows <= '0;
      r_issued   <= '0;
      r_row_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else if (w_start_ok) begin
      r_num_rows <= num_rows;
      r_issued   <= '0;
      r_row_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_acc)  r_issued  <= r_issued + 16'd1;
      if (w_avld) r_row_cnt <= r_row_cnt + 16'd1;
      if (w_drop) r_ovf     <= 1'b1;
    end
  end

`ifdef SYSARR_DRAIN_RELU_EN
  assign m_out.out_data = relu_row(r_out_data);
`else
  assign m_out.out_data = r_out_data;
`endif
  assign m_out.out_vld = (r_cnt != '0);
  assign level         = r_cnt;
  assign ovf           = r_ovf;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
endmodule

// File: tb/tb_sysarr_drain.sv
// Directed bench for sysarr_drain: reset, gating, single row, streaming, overflow,
// zero-row job, reset mid-job and the optional ReLU presentation.
module tb_sysarr_drain;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_rows;
  logic [31:0] ps_in;
  logic        in_vld;
  logic        busy, done, ovf;
  logic [2:0]  level;

  int n_cmp;
  int n_err;
  logic [7:0]  rows [8][4];
  logic [31:0] exp_row [6];

  sysarr_drain_if #(.WORD_LEN(4), .ARR_WDT(4)) u_if ();

  sysarr_drain #(.WORD_LEN(4), .ARR_WDT(4), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_rows (num_rows),
    .ps_in    (ps_in),
    .in_vld   (in_vld),
    .m_out    (u_if.master),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input int k, input logic [7:0] l0, input logic [7:0] l1,
                         input logic [7:0] l2, input logic [7:0] l3);
    rows[k][0] = l0;
    rows[k][1] = l1;
    rows[k][2] = l2;
    rows[k][3] = l3;
  endtask

  // Lane j of row k is on the bus in cycle k+j; row k's in_vld is in cycle k.
  task automatic set_lanes(input int c, input int n);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      if ((c - j) >= 0 && (c - j) < n) v[j*8 +: 8] = rows[c-j][j];
    end
    ps_in  = v;
    in_vld = (c >= 0 && c < n);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; num_rows = '0; ps_in = '0; in_vld = 1'b0;
    u_if.out_rdy = 1'b0;
    exp_row[0] = 32'h03020100;
    exp_row[1] = 32'h13121110;
    exp_row[2] = 32'h23222120;
    exp_row[3] = 32'h33323130;
    exp_row[4] = 32'h43424140;
    exp_row[5] = 32'h53525150;
    step();
    step();
    chk("rst_out_data", u_if.out_data, 0);
    chk("rst_out_vld", u_if.out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", level, 0);

    // in_vld while IDLE must not write the FIFO
    rst = 1'b0;
    in_vld = 1'b1; ps_in = 32'hDEADBEEF;
    step();
    in_vld = 1'b0; ps_in = '0;
    repeat (5) step();
    chk("idle_gate_level", level, 0);
    chk("idle_gate_vld", u_if.out_vld, 0);

    // Single row, plus a surplus in_vld and an ignored start while busy
    set_row(0, 8'h11, 8'h22, 8'h33, 8'h44);
    u_if.out_rdy = 1'b1;
    for (int c = -1; c <= 7; c++) begin
      start    = (c == -1) || (c == 2);
      num_rows = (c == -1) ? 16'd1 : 16'd0;
      set_lanes(c, 1);
      if (c == 1) in_vld = 1'b1;
      if (c == 3) begin
        chk("single_c3_vld", u_if.out_vld, 0);
        chk("single_c3_done", done, 0);
      end
      if (c == 4) begin
        chk("single_c4_vld", u_if.out_vld, 1);
        chk("single_c4_data", u_if.out_data, 32'h44332211);
        chk("single_c4_busy", busy, 1);
        chk("single_c4_done", done, 0);
      end
      if (c == 5) begin
        chk("single_c5_level", level, 0);
        chk("single_c5_vld", u_if.out_vld, 0);
        chk("single_c5_done", done, 0);
      end
      if (c == 6) chk("single_c6_done", done, 1);
      if (c == 7) begin
        chk("single_c7_busy", busy, 0);
        chk("single_c7_done", done, 0);
      end
      step();
    end

    // Streaming four back-to-back rows
    for (int k = 0; k < 6; k++) set_row(k, 8'(16*k), 8'(16*k+1), 8'(16*k+2), 8'(16*k+3));
    for (int c = -1; c <= 10; c++) begin
      start    = (c == -1);
      num_rows = 16'd4;
      set_lanes(c, 4);
      if (c >= 4 && c <= 7) begin
        chk("stream_vld", u_if.out_vld, 1);
        chk("stream_data", u_if.out_data, exp_row[c-4]);
      end
      if (c == 8) begin
        chk("stream_c8_vld", u_if.out_vld, 0);
        chk("stream_c8_ovf", ovf, 0);
      end
      if (c == 9)  chk("stream_c9_done", done, 1);
      if (c == 10) chk("stream_c10_busy", busy, 0);
      step();
    end

    // Overflow: consumer stalled, rows 4 and 5 dropped
    for (int c = -1; c <= 26; c++) begin
      start        = (c == -1);
      num_rows     = 16'd6;
      u_if.out_rdy = (c >= 20);
      set_lanes(c, 6);
      if (c == 7) chk("ovf_c7_level", level, 4);
      if (c == 8) chk("ovf_c8_level", level, 4);
      if (c == 9) begin
        chk("ovf_c9_ovf", ovf, 1);
        chk("ovf_c9_level", level, 4);
      end
      if (c == 15) begin
        chk("ovf_hold_vld", u_if.out_vld, 1);
        chk("ovf_hold_data", u_if.out_data, exp_row[0]);
      end
      if (c >= 20 && c <= 23) chk("ovf_pop_data", u_if.out_data, exp_row[c-20]);
      if (c == 24) begin
        chk("ovf_c24_level", level, 0);
        chk("ovf_c24_vld", u_if.out_vld, 0);
        chk("ovf_c24_done", done, 0);
      end
      if (c == 25) begin
        chk("ovf_c25_done", done, 1);
        chk("ovf_c25_ovf", ovf, 1);
      end
      if (c == 26) begin
        chk("ovf_c26_busy", busy, 0);
        chk("ovf_c26_ovf", ovf, 1);
      end
      step();
    end

    // Zero-row job: immediate done, and the honoured start clears ovf
    for (int c = -1; c <= 1; c++) begin
      start    = (c == -1);
      num_rows = 16'd0;
      set_lanes(c, 0);
      if (c == 0) begin
        chk("zero_c0_done", done, 1);
        chk("zero_c0_vld", u_if.out_vld, 0);
        chk("zero_c0_ovf", ovf, 0);
      end
      if (c == 1) begin
        chk("zero_c1_busy", busy, 0);
        chk("zero_c1_done", done, 0);
      end
      step();
    end

    // Reset in COLLECT aborts the job and flushes rows still in flight
    for (int c = -1; c <= 8; c++) begin
      start    = (c == -1);
      num_rows = 16'd3;
      rst      = (c == 2);
      set_lanes(c, 3);
      if (c == 1) chk("rstjob_c1_busy", busy, 1);
      if (c == 3) begin
        chk("rstjob_c3_data", u_if.out_data, 0);
        chk("rstjob_c3_vld", u_if.out_vld, 0);
        chk("rstjob_c3_busy", busy, 0);
        chk("rstjob_c3_done", done, 0);
        chk("rstjob_c3_ovf", ovf, 0);
        chk("rstjob_c3_level", level, 0);
      end
      if (c >= 4 && c <= 8) chk("rstjob_no_done", done, 0);
      if (c == 8) chk("rstjob_c8_level", level, 0);
      step();
    end

    // Signed lanes at the FIFO head
    set_row(0, 8'hF0, 8'h70, 8'h80, 8'h01);
    u_if.out_rdy = 1'b1;
    for (int c = -1; c <= 7; c++) begin
      start    = (c == -1);
      num_rows = 16'd1;
      set_lanes(c, 1);
      if (c == 4) begin
        chk("relu_vld", u_if.out_vld, 1);
`ifdef SYSARR_DRAIN_RELU_EN
        chk("relu_data", u_if.out_data, 32'h01007000);
`else
        chk("relu_data", u_if.out_data, 32'h018070F0);
`endif
      end
      if (c == 6) chk("relu_done", done, 1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
